// File: rtl/sprite_pkg.sv
// Shared types for the sprite line buffer: chunk record, writer states and
// the planar-to-packed pixel extraction used by the painter.
package sprite_pkg;

  localparam int LB_DEPTH = 512;
  localparam int PIX_W    = 12;

  typedef struct packed {
    logic [8:0]  hp;
    logic [7:0]  oc;
    logic        hf;
    logic [31:0] planes;
  } chunk_t;

  typedef enum logic [1:0] {IDLE, PAINT, CLEAR} wr_state_t;

  // Pixel i (0 = leftmost unflipped) gathers bit 7-i of each byte-wide plane.
  function automatic logic [3:0] chunk_px(input logic [31:0] planes, input logic [2:0] i);
    logic [4:0] j;
    j = {2'b00, i};
    return {planes[5'd31 - j], planes[5'd23 - j], planes[5'd15 - j], planes[5'd7 - j]};
  endfunction

endpackage

// File: rtl/lb_bank.sv
// One line-buffer bank: single-port RAM, synchronous read, read-before-write.
module lb_bank
  import sprite_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic             clk_24M,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [2**AW];

  always_ff @(posedge clk_24M) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite line buffer: paints 8-pixel chunks into the write
// bank while the read bank scans out. Build with K051937_DBG_EN for ovf_cnt.
//
//   state | meaning
//   IDLE  | waiting for a queued chunk
//   PAINT | writing pixel k (0..7) of the FIFO head chunk
//   CLEAR | post-reset sweep zeroing both banks, busy = 1
module sprite_linebuf
  import sprite_pkg::*;
#(
  parameter int XW     = 9,
  parameter int FIFO_D = 2
) (
  input  logic             clk_24M,
  input  logic             reset,
  input  logic             pe_6M,
  input  logic             LACH,
  input  logic [8:0]       HP,
  input  logic [7:0]       OC,
  input  logic             OHF,
  input  logic [31:0]      rom_d,
  input  logic             HEND,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_opq,
  output logic             busy
`ifdef K051937_DBG_EN
  , output logic [7:0]     ovf_cnt
`endif
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);

  chunk_t          fifo_q [FIFO_D];
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  wr_state_t       state;
  logic [2:0]      k;
  logic            bank_sel;
  logic [XW-1:0]   rd_x, clr_cnt, clr_addr;
  logic            clr_pend, clr_bank, rd_valid, rd_bank_q;

  logic            lach_act, hend_act, pe_act, full, push, paint_done;
  chunk_t          head;
  logic [3:0]      px;
  logic            wr_en, rd_bank;
  logic [XW-1:0]   wr_addr, rd_addr;
  logic [XW-1:0]   b_addr  [2];
  logic            b_we    [2];
  logic [PIX_W-1:0] b_wdata [2];
  logic [PIX_W-1:0] b_rdata [2];

  always_comb begin
    lach_act   = LACH  && (state != CLEAR);
    hend_act   = HEND  && (state != CLEAR);
    pe_act     = pe_6M && (state != CLEAR);
    full       = (count == CW'(FIFO_D));
    push       = lach_act && !hend_act && !full;
    head       = fifo_q[rptr];
    px         = chunk_px(head.planes, head.hf ? ~k : k);
    wr_en      = (state == PAINT) && (px != 4'd0) && !hend_act;
    wr_addr    = XW'(head.hp) + XW'(k);
    paint_done = (state == PAINT) && (k == 3'd7) && !hend_act;
    // On HEND the reader already targets the bank that is about to become the read bank.
    rd_bank    = hend_act ? bank_sel : ~bank_sel;
    rd_addr    = hend_act ? '0 : rd_x;
    for (int b = 0; b < 2; b++) begin
      b_addr[b]  = '0;
      b_we[b]    = 1'b0;
      b_wdata[b] = '0;
      if (state == CLEAR) begin
        b_addr[b] = clr_cnt;
        b_we[b]   = 1'b1;
      end else if (pe_act && rd_bank == 1'(b)) begin
        b_addr[b] = rd_addr;
      end else if (clr_pend && clr_bank == 1'(b)) begin
        b_addr[b] = clr_addr;
        b_we[b]   = 1'b1;
      end else if (wr_en && bank_sel == 1'(b)) begin
        b_addr[b]  = wr_addr;
        b_we[b]    = 1'b1;
        b_wdata[b] = {head.oc, px};
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    lb_bank #(.AW(XW)) u_bank (
      .clk_24M (clk_24M),
      .we      (b_we[g]),
      .addr    (b_addr[g]),
      .wdata   (b_wdata[g]),
      .rdata   (b_rdata[g])
    );
  end

  always_ff @(posedge clk_24M) begin
    if (reset) begin
      state     <= CLEAR;
      busy      <= 1'b1;
      clr_cnt   <= '0;
      k         <= '0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      bank_sel  <= 1'b0;
      rd_x      <= '0;
      clr_pend  <= 1'b0;
      clr_addr  <= '0;
      clr_bank  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_bank_q <= 1'b0;
      pix_out   <= '0;
      pix_opq   <= 1'b0;
    end else begin
      clr_pend  <= pe_act;
      clr_addr  <= rd_addr;
      clr_bank  <= rd_bank;
      rd_valid  <= pe_act;
      rd_bank_q <= rd_bank;
      if (rd_valid) begin
        pix_out <= b_rdata[rd_bank_q];
        pix_opq <= |b_rdata[rd_bank_q][3:0];
      end
      if (pe_act)        rd_x <= rd_addr + XW'(1);
      else if (hend_act) rd_x <= '0;
      if (hend_act) bank_sel <= ~bank_sel;

      // The head entry stays queued until fully painted, so it occupies a slot.
      if (hend_act) begin
        count <= '0;
        rptr  <= wptr;
      end else begin
        if (push) begin
          fifo_q[wptr] <= '{hp: HP, oc: OC, hf: OHF, planes: rom_d};
          wptr         <= (wptr == PW'(FIFO_D - 1)) ? '0 : wptr + 1'b1;
        end
        if (paint_done) rptr <= (rptr == PW'(FIFO_D - 1)) ? '0 : rptr + 1'b1;
        count <= count + CW'(push) - CW'(paint_done);
      end

      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + XW'(1);
          if (clr_cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (count != '0 && !hend_act) begin
            state <= PAINT;
            k     <= '0;
          end
        end
        PAINT: begin
          if (hend_act) begin
            state <= IDLE;
          end else begin
            k <= k + 3'd1;
            if (paint_done && count == CW'(1) && !push) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef K051937_DBG_EN
  logic [8:0] ovf_sum;

  always_comb begin
    ovf_sum = {1'b0, ovf_cnt};
    if (hend_act)             ovf_sum = ovf_sum + 9'(count);
    else if (lach_act && full) ovf_sum = ovf_sum + 9'd1;
  end

  always_ff @(posedge clk_24M) begin
    if (reset) ovf_cnt <= '0;
    else       ovf_cnt <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_sprite_linebuf.sv
// Directed bench for sprite_linebuf: paints chunks, swaps banks and scans
// whole lines against hand-set expected pixel maps.
module tb_sprite_linebuf;

  logic        clk_24M = 1'b0;
  logic        reset   = 1'b1;
  logic        pe_6M   = 1'b0;
  logic        LACH    = 1'b0;
  logic [8:0]  HP      = '0;
  logic [7:0]  OC      = '0;
  logic        OHF     = 1'b0;
  logic [31:0] rom_d   = '0;
  logic        HEND    = 1'b0;
  logic [11:0] pix_out;
  logic        pix_opq;
  logic        busy;
`ifdef K051937_DBG_EN
  logic [7:0]  ovf_cnt;
`endif

  int          n_chk = 0;
  int          n_bad = 0;
  logic [11:0] exp_line [512];
  int          n_busy;

  always #5 clk_24M = ~clk_24M;

  sprite_linebuf dut (
    .clk_24M (clk_24M),
    .reset   (reset),
    .pe_6M   (pe_6M),
    .LACH    (LACH),
    .HP      (HP),
    .OC      (OC),
    .OHF     (OHF),
    .rom_d   (rom_d),
    .HEND    (HEND),
    .pix_out (pix_out),
    .pix_opq (pix_opq),
    .busy    (busy)
`ifdef K051937_DBG_EN
    , .ovf_cnt (ovf_cnt)
`endif
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_24M);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic lach_chunk(input logic [8:0] hp, input logic [7:0] oc, input logic hf,
                            input logic [31:0] d);
    HP = hp; OC = oc; OHF = hf; rom_d = d; LACH = 1'b1;
    tick();
    LACH = 1'b0;
  endtask

  task automatic hend_pulse();
    HEND = 1'b1;
    tick();
    HEND = 1'b0;
  endtask

  task automatic exp_clear();
    for (int i = 0; i < 512; i++) exp_line[i] = '0;
  endtask

  task automatic scan_check(input string tag);
    for (int x = 0; x < 512; x++) begin
      pe_6M = 1'b1;
      tick();
      pe_6M = 1'b0;
      tick();
      chk($sformatf("%s_pix_x%0d", tag, x), 32'(pix_out), 32'(exp_line[x]));
      chk($sformatf("%s_opq_x%0d", tag, x), 32'(pix_opq), 32'(exp_line[x][3:0] != 4'd0));
    end
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run time exceeded");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_pix", 32'(pix_out), 32'd0);
    chk("reset_opq", 32'(pix_opq), 32'd0);
    wait_busy(n_busy);
    chk("reset_busy_len", 32'(n_busy), 32'd512);

    // Single unflipped chunk, plane 3 only -> nibble 8.
    lach_chunk(9'd16, 8'h3A, 1'b0, 32'hFF00_0000);
    tick(12);
    hend_pulse();
    exp_clear();
    for (int x = 16; x <= 23; x++) exp_line[x] = 12'h3A8;
    scan_check("single");

    // Flipped single pixel plus a chunk wrapping past X511.
    lach_chunk(9'd100, 8'h55, 1'b1, 32'h0000_0001);
    tick(12);
    lach_chunk(9'd510, 8'h77, 1'b0, 32'h0000_00FF);
    tick(12);
    hend_pulse();
    exp_clear();
    exp_line[100] = 12'h551;
    exp_line[510] = 12'h771;
    exp_line[511] = 12'h771;
    for (int x = 0; x <= 5; x++) exp_line[x] = 12'h771;
    scan_check("flip_wrap");

    // Back-to-back chunks at X0: third dropped, second overwrites first.
    lach_chunk(9'd0, 8'h11, 1'b0, 32'hFFFF_FFFF);
    lach_chunk(9'd0, 8'h22, 1'b0, 32'hFFFF_FFFF);
    lach_chunk(9'd0, 8'h33, 1'b0, 32'hFFFF_FFFF);
    tick(25);
`ifdef K051937_DBG_EN
    chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    hend_pulse();
    exp_clear();
    for (int x = 0; x <= 7; x++) exp_line[x] = 12'h22F;
    scan_check("overlap");

    // Two swaps without painting: the bank just scanned must read back empty.
    hend_pulse();
    tick(2);
    hend_pulse();
    exp_clear();
    scan_check("clear_behind");

    // Reset while painting; LACH/pe/HEND during the sweep are ignored.
    lach_chunk(9'd200, 8'h66, 1'b0, 32'hFFFF_FFFF);
    tick(3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_busy", 32'(busy), 32'd1);
    lach_chunk(9'd300, 8'h44, 1'b0, 32'hFFFF_FFFF);
    pe_6M = 1'b1;
    tick();
    pe_6M = 1'b0;
    hend_pulse();
    chk("mid_reset_pix", 32'(pix_out), 32'd0);
    wait_busy(n_busy);
    chk("mid_reset_busy_len", 32'(n_busy + 3), 32'd512);
    tick(20);
    hend_pulse();
    exp_clear();
    scan_check("post_reset_a");
    hend_pulse();
    scan_check("post_reset_b");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
